uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Memory-mapped serial output port for the 8-bit single-cycle processor, sitting directly downstream of the data-memory write path alongside the parallel output port. A store whose ULA-computed address matches the port address pushes the store data, taken from register-file read port 2, into a small FIFO. An internal state machine serializes each byte as 8N1 on `UART_TXD`. A status byte is exposed so the parallel input mux can return it to `lw` instructions.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per bit, ≥2 (50 MHz / 115200).
- `DATA_ADDR`, 8'hFE: store address that enqueues a byte.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `we`  in  1  store strobe (MemWrite), one cycle per store in `clk` domain.
- `Address`  in  8  store address (ULA result).
- `WData`  in  8  store data (rd2).
- `UART_TXD`  out  1  serial line, idle high.
- `Status`  out  8  {4'b0, overflow, empty, full, busy}.
- `Count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push: `we && Address==DATA_ADDR`, accepted if not full, or if a pop occurs in the same cycle.
- Overflow: a push while full with no same-cycle pop discards the data and leaves FIFO contents unchanged.
- `overflow` is sticky. It is set by a discarded push and cleared only by reset.
- Stores to other addresses are ignored.
- FIFO is circular, with write/read pointers of width $clog2(DEPTH) that wrap modulo DEPTH; `Count` = pushes − pops.
- FSM states: IDLE, START, DATA, STOP (PARITY added under the macro).
  - IDLE: if FIFO is non-empty, pop the head into shift register `sh`, clear the baud counter, go to START.
  - START: `UART_TXD`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: `UART_TXD`=sh[idx], LSB first, CLKS_PER_BIT cycles per bit. After idx 7, go to STOP.
  - STOP: `UART_TXD`=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter runs 0..CLKS_PER_BIT−1. At terminal count it resets to 0 and the state/bit advances.
- `busy` = state≠IDLE; `empty` = Count==0; `full` = Count==DEPTH.
- Back-to-back bytes: STOP→IDLE→START costs exactly one extra idle-high cycle between frames.
- `UART_TXD` is driven from a register (no glitches).

## Timing
- Reset values: `UART_TXD`=1, FSM=IDLE, pointers/Count=0, `Status`=8'h04 (empty only), `overflow`=0.
- Reset asserted mid-frame: line returns high immediately (asynchronously), FIFO contents are lost, and the frame is aborted.
- Push sampled at edge E0: `Count` increments after E0.
- With FSM in IDLE, the pop happens at E1. `UART_TXD` falls after E1, and `Count` decrements after E1.
- Frame length: 10·CLKS_PER_BIT cycles from the start-bit falling edge to the end of the stop bit.
- Simultaneous push and pop in one cycle: `Count` is unchanged and both operations take effect.
- `Status` and `Count` are registered-state-derived and valid in the cycle after the causing edge.

## Configuration
- `UART_TX_PARITY_EN`: when defined, a PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (^sh) for CLKS_PER_BIT cycles.
  - Frame becomes 11·CLKS_PER_BIT cycles.
- When undefined: plain 8N1 with 10-bit frames, and the PARITY state and its logic are absent.

## Test plan
All scenarios use CLKS_PER_BIT=4, DEPTH=4.
- Reset then idle: `UART_TXD`=1, `Status`=8'h04, `Count`=0 for 50 cycles.
- Single store of 8'hA5 to 8'hFE: `UART_TXD` falls 2 edges later. It then shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; `busy` is high for 40 cycles; `Status` returns to 8'h04.
- Store to 8'h10 with `we`=1: no push, `Count`=0, line stays high.
- Six back-to-back stores 8'h01..8'h06 while idle:
  - The first is popped immediately; 8'h02..8'h05 fill the FIFO (`full`=1).
  - 8'h06 is dropped, `overflow`=1, `Status`=8'h0B.
  - Line emits 01..05 in order, each frame separated by one idle cycle.
- Assert `rst` low during DATA bit 3: `UART_TXD`=1 immediately and `Count`=0. After release, the line stays idle.
- With `UART_TX_PARITY_EN` defined, store 8'h07: the parity bit is 1 and the frame is 44 cycles long.

Source files
------------

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial output port: stores to DATA_ADDR are queued in a small FIFO and shifted out on UART_TXD.
// Optional even parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_port #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] DATA_ADDR    = 8'hFE,
    parameter int         DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [7:0]               Address,
    input  logic [7:0]               WData,
    output logic                     UART_TXD,
    output logic [7:0]               Status,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic            txd_q, txd_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            baud_done;
    logic            pop;
    logic            push_req;
    logic            push_ok;
    logic            fifo_full;
    logic            fifo_empty;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign baud_done  = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign push_req   = we && (Address == DATA_ADDR);
    // A full FIFO still accepts a push when the transmitter frees a slot in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is computed from the next state so UART_TXD comes straight off a flop.
        txd_d = 1'b1;
        case (state_d)
            START:  txd_d = 1'b0;
            DATA:   txd_d = sh_d[idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_d = ^sh_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = WData;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            idx_q      <= 3'd0;
            sh_q       <= 8'h00;
            txd_q      <= 1'b1;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            txd_q      <= txd_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign UART_TXD = txd_q;
    assign Status   = {4'b0000, overflow_q, fifo_empty, fifo_full, (state_q != IDLE)};
    assign Count    = count_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: directed scenarios plus randomized stores against a frame-level model.
// Define UART_TX_PARITY_EN for both bench and design to exercise the parity frame.
module tb_uart_tx_port;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       we      = 1'b0;
    logic [7:0] Address = 8'h00;
    logic [7:0] WData   = 8'h00;
    logic       UART_TXD;
    logic [7:0] Status;
    logic [2:0] Count;

    int passed = 0;
    int total  = 0;

    // Frame-level reference: queued bytes, remaining cycles of the current frame, sticky overflow.
    logic [7:0] mq[$];
    int         remaining = 0;
    logic [7:0] cur = 8'h00;
    bit         movf = 1'b0;

    uart_tx_port #(
        .CLKS_PER_BIT(CPB),
        .DATA_ADDR(8'hFE),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .Address(Address),
        .WData(WData),
        .UART_TXD(UART_TXD),
        .Status(Status),
        .Count(Count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        remaining = 0;
        cur       = 8'h00;
        movf      = 1'b0;
    endtask

    task automatic model_edge(input bit push_req, input logic [7:0] data);
        bit do_pop;
        int sz;
        sz     = mq.size();
        do_pop = (remaining == 0) && (sz != 0);
        if (do_pop) begin
            cur       = mq.pop_front();
            remaining = FRAME;
        end else if (remaining > 0) begin
            remaining--;
        end
        if (push_req) begin
            if (sz < DEPTH || do_pop) mq.push_back(data);
            else movf = 1'b1;
        end
    endtask

    function automatic logic exp_txd();
        int pos;
        if (remaining == 0) return 1'b1;
        pos = (FRAME - remaining) / CPB;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return cur[pos-1];
`ifdef UART_TX_PARITY_EN
        if (pos == 9) return ^cur;
`endif
        return 1'b1;
    endfunction

    function automatic logic [7:0] exp_status();
        return {4'b0000, movf, (mq.size() == 0), (mq.size() == DEPTH), (remaining != 0)};
    endfunction

    function automatic logic [2:0] exp_count();
        return 3'(mq.size());
    endfunction

    task automatic cycle(input bit w, input logic [7:0] a, input logic [7:0] d);
        we      = w;
        Address = a;
        WData   = d;
        @(posedge clk);
        model_edge(w && (a == 8'hFE), d);
        #1;
    endtask

    task automatic apply_reset();
        we  = 1'b0;
        rst = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        total++;
        if ({UART_TXD, Status, Count} !== {1'b1, 8'h04, 3'd0}) $display("[TB] FAIL reset_async got=%0h exp=%0h", {UART_TXD, Status, Count}, {1'b1, 8'h04, 3'd0});
        else passed++;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 8'h00, 8'h00);
            total++;
            if ({UART_TXD, Status, Count} !== {1'b1, 8'h04, 3'd0}) $display("[TB] FAIL reset_idle cyc=%0d got=%0h exp=%0h", i, {UART_TXD, Status, Count}, {1'b1, 8'h04, 3'd0});
            else passed++;
        end
    endtask

    task automatic test_single();
        bit pat [NBITS];
        int busy;
`ifdef UART_TX_PARITY_EN
        pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
        busy = 0;
        cycle(1'b1, 8'hFE, 8'hA5);
        total++;
        if ({UART_TXD, Count} !== {1'b1, 3'd1}) $display("[TB] FAIL single_after_push got=%0h exp=%0h", {UART_TXD, Count}, {1'b1, 3'd1});
        else passed++;
        cycle(1'b0, 8'h00, 8'h00);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) cycle(1'b0, 8'h00, 8'h00);
            total++;
            if (UART_TXD !== pat[k/CPB]) $display("[TB] FAIL single_bit k=%0d got=%0b exp=%0b", k, UART_TXD, pat[k/CPB]);
            else passed++;
            if (Status[0] === 1'b1) busy++;
        end
        cycle(1'b0, 8'h00, 8'h00);
        total++;
        if (busy !== FRAME) $display("[TB] FAIL single_busy_len got=%0d exp=%0d", busy, FRAME);
        else passed++;
        total++;
        if ({UART_TXD, Status, Count} !== {1'b1, 8'h04, 3'd0}) $display("[TB] FAIL single_idle_after got=%0h exp=%0h", {UART_TXD, Status, Count}, {1'b1, 8'h04, 3'd0});
        else passed++;
    endtask

    task automatic test_other_addr();
        cycle(1'b1, 8'h10, 8'h5A);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) cycle(1'b0, 8'h00, 8'h00);
            total++;
            if ({UART_TXD, Status, Count} !== {1'b1, 8'h04, 3'd0}) $display("[TB] FAIL other_addr cyc=%0d got=%0h exp=%0h", i, {UART_TXD, Status, Count}, {1'b1, 8'h04, 3'd0});
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bit         line[$];
        logic [7:0] got[$];
        int         gaps[$];
        int         guard;
        int         j;
        int         last_end;
        logic [7:0] b;
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 8'hFE, 8'(i));
            line.push_back(UART_TXD);
        end
        total++;
        if ({Status, Count} !== {8'h0B, 3'd4}) $display("[TB] FAIL b2b_status got=%0h exp=%0h", {Status, Count}, {8'h0B, 3'd4});
        else passed++;
        guard = 0;
        while ((mq.size() != 0 || remaining != 0) && guard < 1000) begin
            cycle(1'b0, 8'h00, 8'h00);
            line.push_back(UART_TXD);
            total++;
            if (UART_TXD !== exp_txd()) $display("[TB] FAIL b2b_line cyc=%0d got=%0b exp=%0b", guard, UART_TXD, exp_txd());
            else passed++;
            guard++;
        end
        total++;
        if (guard >= 1000) $display("[TB] FAIL b2b_drain_timeout got=%0d exp=<1000", guard);
        else passed++;
        repeat (5) begin
            cycle(1'b0, 8'h00, 8'h00);
            line.push_back(UART_TXD);
        end
        j = 0;
        last_end = -1;
        while (j < line.size()) begin
            if (line[j] == 1'b0) begin
                if (j + FRAME > line.size()) break;
                if (last_end >= 0) gaps.push_back(j - last_end);
                for (int bi = 0; bi < 8; bi++) b[bi] = line[j + CPB*(1+bi) + CPB/2];
                got.push_back(b);
                last_end = j + FRAME;
                j = last_end;
            end else begin
                j++;
            end
        end
        total++;
        if (got.size() !== 5) $display("[TB] FAIL b2b_frames got=%0d exp=5", got.size());
        else passed++;
        for (int i = 0; i < got.size() && i < 5; i++) begin
            total++;
            if (got[i] !== 8'(i+1)) $display("[TB] FAIL b2b_byte idx=%0d got=%0h exp=%0h", i, got[i], 8'(i+1));
            else passed++;
        end
        for (int i = 0; i < gaps.size(); i++) begin
            total++;
            if (gaps[i] !== 1) $display("[TB] FAIL b2b_gap idx=%0d got=%0d exp=1", i, gaps[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        cycle(1'b1, 8'hFE, 8'hF0);
        cycle(1'b1, 8'hFE, 8'h33);
        repeat (4*CPB + 1) cycle(1'b0, 8'h00, 8'h00);
        total++;
        if ({UART_TXD, Count} !== {1'b0, 3'd1}) $display("[TB] FAIL midframe_pre got=%0h exp=%0h", {UART_TXD, Count}, {1'b0, 3'd1});
        else passed++;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({UART_TXD, Status, Count} !== {1'b1, 8'h04, 3'd0}) $display("[TB] FAIL midframe_async got=%0h exp=%0h", {UART_TXD, Status, Count}, {1'b1, 8'h04, 3'd0});
        else passed++;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 8'h00, 8'h00);
            total++;
            if ({UART_TXD, Count} !== {1'b1, 3'd0}) $display("[TB] FAIL midframe_after cyc=%0d got=%0h exp=%0h", i, {UART_TXD, Count}, {1'b1, 3'd0});
            else passed++;
        end
    endtask

    task automatic test_random();
        int         rate [3];
        int         len  [3];
        bit         w;
        logic [7:0] a;
        rate = '{40, 3, 50};
        len  = '{500, 300, 400};
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < len[p]; i++) begin
                w = ($urandom_range(0, rate[p] - 1) == 0);
                a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFE;
                cycle(w, a, 8'($urandom));
                total++;
                if (UART_TXD !== exp_txd()) $display("[TB] FAIL rand_txd ph=%0d cyc=%0d got=%0b exp=%0b", p, i, UART_TXD, exp_txd());
                else passed++;
                total++;
                if (Status !== exp_status()) $display("[TB] FAIL rand_status ph=%0d cyc=%0d got=%0h exp=%0h", p, i, Status, exp_status());
                else passed++;
                total++;
                if (Count !== exp_count()) $display("[TB] FAIL rand_count ph=%0d cyc=%0d got=%0d exp=%0d", p, i, Count, exp_count());
                else passed++;
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int   busy;
        logic par;
        apply_reset();
        busy = 0;
        par  = 1'b0;
        cycle(1'b1, 8'hFE, 8'h07);
        cycle(1'b0, 8'h00, 8'h00);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) cycle(1'b0, 8'h00, 8'h00);
            if (k == 9*CPB + 1) par = UART_TXD;
            if (Status[0] === 1'b1) busy++;
        end
        cycle(1'b0, 8'h00, 8'h00);
        total++;
        if (par !== 1'b1) $display("[TB] FAIL parity_bit got=%0b exp=1", par);
        else passed++;
        total++;
        if (busy !== 11*CPB) $display("[TB] FAIL parity_frame_len got=%0d exp=%0d", busy, 11*CPB);
        else passed++;
        total++;
        if ({UART_TXD, Status} !== {1'b1, 8'h04}) $display("[TB] FAIL parity_idle_after got=%0h exp=%0h", {UART_TXD, Status}, {1'b1, 8'h04});
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_other_addr();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
